// File: rtl/drum_arb_pkg.sv
// Shared constants, ID-width helper and S1 stage record for drum_mul_arbiter.
// Build option DRUM_ARB_EXACT_EN is consumed by the top level, not here.
package drum_arb_pkg;

  localparam int DEF_K    = 6;
  localparam int DEF_N    = 16;
  localparam int DEF_M    = 16;
  localparam int DEF_NREQ = 4;

  // S1 record fields are sized for the largest supported configuration
  localparam int MAX_OPW = 32;
  localparam int MAX_IDW = 3;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_OPW-1:0] a;
    logic [MAX_OPW-1:0] b;
    logic [MAX_IDW-1:0] id;
    logic               exact;
    logic               valid;
  } s1_rec_t;

endpackage

// File: rtl/drum_rr_arb.sv
// Round-robin grant: search starts at ptr, ptr moves past the winner on advance.
module drum_rr_arb import drum_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int IW = id_width(NREQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (int'(gidx) == NREQ - 1) begin
        ptr <= '0;
      end else begin
        ptr <= gidx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/drum_mul_arbiter.sv
// Round-robin arbitrated, two-stage pipelined DRUM-K approximate multiplier.
// Defining DRUM_ARB_EXACT_EN adds req_exact for per-request exact signed products.
module drum_mul_arbiter import drum_arb_pkg::*; #(
  parameter int K    = DEF_K,
  parameter int N    = DEF_N,
  parameter int M    = DEF_M,
  parameter int NREQ = DEF_NREQ
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*N-1:0]             req_a,
  input  logic [NREQ*M-1:0]             req_b,
`ifdef DRUM_ARB_EXACT_EN
  input  logic [NREQ-1:0]               req_exact,
`endif
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N+M-1:0]                res_data,
  output logic [id_width(NREQ)-1:0]     res_id
);

  localparam int IW = id_width(NREQ);
  localparam int PW = N + M;

  s1_rec_t         s1;
  logic            s2_valid;
  logic            s2_load;
  logic            s1_can;
  logic            any_req;
  logic            unused_s1;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_idx;
  logic [N-1:0]    a_sel;
  logic [M-1:0]    b_sel;
  logic            ex_sel;

  logic [N-1:0]    op_a, mag_a, mul_x;
  logic [M-1:0]    op_b, mag_b, mul_y;
  logic            sgn_a, sgn_b;
  logic [K-1:0]    sel_a, sel_b;
  int              lo_a, lo_b, sh_a, sh_b, shamt;
  logic [PW-1:0]   mul_p, product;

  assign s2_load   = !s2_valid || res_ready;
  // rst gating keeps req_ready low for the whole reset pulse
  assign s1_can    = (!s1.valid || s2_load) && !rst;
  assign any_req   = |req_valid;
  assign req_ready = grant & {NREQ{s1_can}};
  assign res_valid = s2_valid;
  assign unused_s1 = ^{s1.a, s1.b, s1.id, s1.exact};

  drum_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (s1_can && any_req),
    .grant   (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx = IW'(i);
      end
    end
  end

  assign a_sel = req_a[int'(gnt_idx)*N +: N];
  assign b_sel = req_b[int'(gnt_idx)*M +: M];
`ifdef DRUM_ARB_EXACT_EN
  assign ex_sel = req_exact[gnt_idx];
`else
  assign ex_sel = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (s1_can) begin
      s1.valid <= any_req;
      s1.a     <= MAX_OPW'(a_sel);
      s1.b     <= MAX_OPW'(b_sel);
      s1.id    <= MAX_IDW'(gnt_idx);
      s1.exact <= ex_sel;
    end
  end

  assign op_a = s1.a[N-1:0];
  assign op_b = s1.b[M-1:0];

  // DRUM uses ones' complement for sign handling, so -1 has magnitude 0
  always_comb begin
    sgn_a = op_a[N-1];
    sgn_b = op_b[M-1];
    mag_a = sgn_a ? ~op_a : op_a;
    mag_b = sgn_b ? ~op_b : op_b;
    lo_a  = 0;
    lo_b  = 0;
    for (int i = 0; i < N; i++) begin
      if (mag_a[i]) lo_a = i;
    end
    for (int i = 0; i < M; i++) begin
      if (mag_b[i]) lo_b = i;
    end
    sh_a  = (lo_a >= K) ? lo_a - K + 1 : 0;
    sh_b  = (lo_b >= K) ? lo_b - K + 1 : 0;
    sel_a = K'(mag_a >> sh_a);
    sel_b = K'(mag_b >> sh_b);
    if (lo_a >= K) sel_a[0] = 1'b1;
    if (lo_b >= K) sel_b[0] = 1'b1;
    mul_x = N'(sel_a);
    mul_y = M'(sel_b);
    shamt = sh_a + sh_b;
`ifdef DRUM_ARB_EXACT_EN
    if (s1.exact) begin
      mul_x = sgn_a ? -op_a : op_a;
      mul_y = sgn_b ? -op_b : op_b;
      shamt = 0;
    end
`endif
    mul_p   = PW'(mul_x) * PW'(mul_y);
    product = (sgn_a ^ sgn_b) ? ~(mul_p << shamt) : (mul_p << shamt);
`ifdef DRUM_ARB_EXACT_EN
    if (s1.exact) begin
      product = (sgn_a ^ sgn_b) ? -mul_p : mul_p;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_data <= '0;
      res_id   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1.valid;
      res_data <= product;
      res_id   <= s1.id[IW-1:0];
    end
  end

endmodule

// File: doc/drum_mul_arbiter.md
DRUM_MUL_ARBITER -- requirements
Module: drum_mul_arbiter

Interface
REQ-001 Parameters SHALL be: K, default 6, DRUM approximation width; N, default 16, operand A width; M, default 16, operand B width; NREQ, default 4, number of requesters (2..8).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_a  in  NREQ*N  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*M  packed operand B; slice i belongs to requester i.
- req_exact  in  NREQ  per-requester exact-mode bit; present only with DRUM_ARB_EXACT_EN.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  N+M  product.
- res_id  out  max(1,$clog2(NREQ))  index of the requester that owns res_data.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 Datapath SHALL be two register stages: S1 holds the granted operands, ID and mode; S2 holds the product, ID and valid.
REQ-005 One shared DRUM multiplier SHALL sit combinationally between S1 and S2; no other multiplier instance is allowed.
REQ-006 Operands SHALL be two's complement. The result SHALL equal the DRUM-K function: conditionally invert negative operands; select K bits from the leading one, with LSB forced to 1 when the leading-one position is >= K; multiply; shift left by the summed offsets; invert the result when the operand signs differ.
REQ-007 An operand below 2^(K-1) in magnitude SHALL be multiplied exactly.
REQ-008 Arbitration SHALL be round-robin: priority starts at the requester after the last granted one; requester 0 has top priority after reset.
REQ-009 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-010 req_ready SHALL be combinational from req_valid, the priority pointer and S1 capacity.
REQ-011 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; the priority pointer SHALL advance only on a transfer.
REQ-012 S1 SHALL accept when S1 is empty or S1 moves to S2 in the same cycle.
REQ-013 S2 SHALL load when S2 is empty or res_valid and res_ready are both high.
REQ-014 Latency SHALL be 2 cycles from the request transfer to res_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-015 While res_valid is high and res_ready is low, res_data and res_id SHALL hold stable; S1 stalls once full, and all req_ready bits are then low.
REQ-016 Results SHALL leave in grant order; none SHALL be dropped or duplicated.
REQ-017 A requester that drops req_valid before it is granted SHALL lose nothing; the pointer stays unchanged.

Reset
REQ-018 Asserting rst at any time SHALL clear the S1/S2 valids, the pointer (to 0), res_valid, res_data, res_id and req_ready immediately; in-flight operations are discarded.
REQ-019 The first request transfer SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-020 Macro DRUM_ARB_EXACT_EN SHALL add the req_exact port.
- Defined: a request with req_exact=1 is computed as an exact signed N x M product through the same S1/S2 timing.
- Undefined: the port is absent and all products are DRUM-K.

Structure
REQ-021 Package drum_arb_pkg SHALL hold the ID width function, the default K/N/M/NREQ constants and the S1 stage record typedef (operands, ID, mode, valid).
REQ-022 Round-robin grant logic SHALL be sub-module drum_rr_arb, parameterised by NREQ, with ports req, advance, grant and clk/rst.

Verification
REQ-023 Requester 2 sends a=3, b=5; res_ready=1 -> res_data=15, res_id=2, exactly 2 cycles after the transfer.
REQ-024 a=0x00FF, b=1 -> res_data=252; with DRUM_ARB_EXACT_EN and req_exact=1 -> 255.
REQ-025 a=0xFFFF, b=2 -> res_data=0xFFFFFFFF.
REQ-026 All 4 requesters hold valid for 8 transfers -> grant order 0,1,2,3,0,1,2,3 and res_id follows the same order.
REQ-027 res_ready held low for 5 cycles with 4 requests pending -> at most 2 in flight, all req_ready low, res_data stable; after release, all 4 results arrive in order.
REQ-028 rst pulsed with S1 and S2 full -> res_valid=0 at once; a post-reset request from requester 3 is granted first and returns correctly.
